clint: RTL



---
 rtl/clint_pkg.sv | 27 ++
 rtl/clint.sv | 115 +++++++++++
 2 files changed

// File: rtl/clint_pkg.sv
// Shared constants and register-state types for the core-local interruptor.
package clint_pkg;

  // Word offsets inside the 64 KiB window (base already stripped by the decoder).
  localparam logic [15:0] clint_msip_off      = 16'h0000;
  localparam logic [15:0] clint_mtimecmp_off  = 16'h4000;
  localparam logic [15:0] clint_mtimecmph_off = 16'h4004;
  localparam logic [15:0] clint_mtime_off     = 16'hBFF8;
  localparam logic [15:0] clint_mtimeh_off    = 16'hBFFC;

  // Architectural state plus the prescaler count, updated together each cycle.
  typedef struct packed {
    logic        msip;
    logic [63:0] mtimecmp;
    logic [63:0] mtime;
    logic [15:0] count;
  } clint_reg_type;

  // mtimecmp starts at all-ones so no timer interrupt fires before software sets it.
  localparam clint_reg_type init_clint_reg = '{
    msip:     1'b0,
    mtimecmp: 64'hFFFF_FFFF_FFFF_FFFF,
    mtime:    64'h0,
    count:    16'h0
  };

endpackage

// File: rtl/clint.sv
// Core-local interruptor: msip register, 64-bit mtime with prescaler, mtimecmp
// compare, and a single-cycle-latency bus slave for all of them.
module clint
  import clint_pkg::*;
#(
  parameter int rtc_div = 50
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        clint_valid,
  input  logic        clint_instr,
  input  logic [31:0] clint_addr,
  input  logic [31:0] clint_wdata,
  input  logic [3:0]  clint_wstrb,
  output logic [31:0] clint_rdata,
  output logic        clint_ready,
  output logic        clint_msip,
  output logic        clint_mtip,
  output logic [63:0] clint_mtime
);

  localparam logic [15:0] count_max = 16'(rtc_div - 1);

  clint_reg_type r_reg, r_next;
  logic          ready_reg, ready_next;
  logic [31:0]   rdata_reg, rdata_next;
  logic          mtip_reg, mtip_next;

  logic [31:0]   lane_mask;
  logic [15:0]   offset;
  logic          is_write;
  logic          tick;
  logic          unused_addr;

  // Expand the byte strobes into a 32-bit bit mask, one lane per strobe.
  generate
    for (genvar gi = 0; gi < 4; gi++) begin : g_lane
      assign lane_mask[8*gi +: 8] = {8{clint_wstrb[gi]}};
    end
  endgenerate

  // Only [15:2] select a register; the rest of the address is don't-care.
  assign offset      = {clint_addr[15:2], 2'b00};
  assign unused_addr = ^{clint_addr[31:16], clint_addr[1:0]};

  // Instruction fetches never write, whatever the strobes say.
  assign is_write = (clint_wstrb != 4'b0000) && !clint_instr;
  assign tick     = (r_reg.count == count_max);

  function automatic logic [31:0] merge_word(input logic [31:0] old_word);
    return (old_word & ~lane_mask) | (clint_wdata & lane_mask);
  endfunction

  // Next-state: prescaler tick, timer increment, register writes and read mux.
  always_comb begin
    r_next     = r_reg;
    rdata_next = '0;
    ready_next = clint_valid;
    mtip_next  = (r_reg.mtime >= r_reg.mtimecmp);

    if (tick) begin
      r_next.count = '0;
      r_next.mtime = r_reg.mtime + 64'd1;
    end else begin
      r_next.count = r_reg.count + 16'd1;
    end

    if (clint_valid) begin
      if (is_write) begin
        // A written mtime half overrides the tick; the other half holds its
        // old value and deliberately drops any increment or carry.
        case (offset)
          clint_msip_off:      if (clint_wstrb[0]) r_next.msip = clint_wdata[0];
          clint_mtimecmp_off:  r_next.mtimecmp[31:0]  = merge_word(r_reg.mtimecmp[31:0]);
          clint_mtimecmph_off: r_next.mtimecmp[63:32] = merge_word(r_reg.mtimecmp[63:32]);
          clint_mtime_off:     r_next.mtime = {r_reg.mtime[63:32], merge_word(r_reg.mtime[31:0])};
          clint_mtimeh_off:    r_next.mtime = {merge_word(r_reg.mtime[63:32]), r_reg.mtime[31:0]};
          default: ;
        endcase
      end else begin
        // Reads see the values held before this edge's updates.
        case (offset)
          clint_msip_off:      rdata_next = {31'b0, r_reg.msip};
          clint_mtimecmp_off:  rdata_next = r_reg.mtimecmp[31:0];
          clint_mtimecmph_off: rdata_next = r_reg.mtimecmp[63:32];
          clint_mtime_off:     rdata_next = r_reg.mtime[31:0];
          clint_mtimeh_off:    rdata_next = r_reg.mtime[63:32];
          default:             rdata_next = '0;
        endcase
      end
    end
  end

  // State register; reset also drops any response that was about to be issued.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_reg     <= init_clint_reg;
      ready_reg <= 1'b0;
      rdata_reg <= '0;
      mtip_reg  <= 1'b0;
    end else begin
      r_reg     <= r_next;
      ready_reg <= ready_next;
      rdata_reg <= rdata_next;
      mtip_reg  <= mtip_next;
    end
  end

  assign clint_ready = ready_reg;
  assign clint_rdata = rdata_reg;
  assign clint_msip  = r_reg.msip;
  assign clint_mtip  = mtip_reg;
  assign clint_mtime = r_reg.mtime;

endmodule
